alu_issue_stage: RTL

// - RV64I ALU issue stage: decodes one 32-bit instruction per cycle into ALU controls and operands.
// - Control outputs are alu_sel and alu_shift_amt; operands are alu_data_in_a and alu_data_in_b.
// - Registers the decoded result behind a valid/ready handshake.
// - Sits between register-file read and the combinational ALU; the producer side of the ALU interface.

---
 rtl/alu_pkg.sv | 52 +++++
 rtl/alu_issue_stage_if.sv | 28 ++
 rtl/alu_op_decoder.sv | 162 ++++++++++++++++
 rtl/alu_issue_stage.sv | 94 +++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the RV64I ALU issue stage: op codes, opcode constants and
// the decoded issue record passed from the decoder to the stage registers.
package alu_pkg;

    localparam int XLEN       = 64;
    localparam int SEL_SIZE   = 5;
    localparam int SHIFT_SIZE = 6;

    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_SLT   = 5'd2,
        ALU_SLTU  = 5'd3,
        ALU_AND   = 5'd4,
        ALU_OR    = 5'd5,
        ALU_XOR   = 5'd6,
        ALU_SLL   = 5'd7,
        ALU_SRL   = 5'd8,
        ALU_SRA   = 5'd9,
        ALU_LUI   = 5'd10,
        ALU_AUIPC = 5'd11,
        ALU_ADDW  = 5'd12,
        ALU_SUBW  = 5'd13,
        ALU_SLLW  = 5'd14,
        ALU_SRLW  = 5'd15,
        ALU_SRAW  = 5'd16
    } alu_op_e;

    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_op_e                sel;
        logic [SHIFT_SIZE-1:0]  shift_amt;
        logic [XLEN-1:0]        a;
        logic [XLEN-1:0]        b;
        logic [4:0]             rd;
        logic                   illegal;
    } alu_issue_t;

    function automatic logic [XLEN-1:0] sext12(input logic [11:0] imm);
        return {{(XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Producer-to-ALU bus of the issue stage: decoded controls, operands and the
// valid/ready pair. The stage drives the master side, the ALU is the slave.
interface alu_issue_stage_if;
    import alu_pkg::*;

    logic                   out_valid;
    logic                   out_ready;
    logic                   alu_enable;
    logic [SEL_SIZE-1:0]    alu_sel;
    logic [SHIFT_SIZE-1:0]  alu_shift_amt;
    logic [XLEN-1:0]        alu_data_in_a;
    logic [XLEN-1:0]        alu_data_in_b;
    logic [4:0]             out_rd;
    logic                   out_illegal;

    modport master (
        output out_valid, alu_enable, alu_sel, alu_shift_amt,
               alu_data_in_a, alu_data_in_b, out_rd, out_illegal,
        input  out_ready
    );

    modport slave (
        input  out_valid, alu_enable, alu_sel, alu_shift_amt,
               alu_data_in_a, alu_data_in_b, out_rd, out_illegal,
        output out_ready
    );

endinterface

// File: rtl/alu_op_decoder.sv
// Combinational RV64I integer-op decoder: instruction word, pc and register
// operands in, one alu_issue_t out. Anything not an ALU op comes out as illegal.
module alu_op_decoder
    import alu_pkg::*;
(
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output alu_issue_t      issue
);

    logic [6:0]             opcode;
    logic [2:0]             f3;
    logic [6:0]             f7;
    logic [XLEN-1:0]        imm_sext;
    logic [XLEN-1:0]        upper_zext;

    alu_op_e                op_v;
    logic                   legal_v;
    logic [XLEN-1:0]        a_v;
    logic [XLEN-1:0]        b_v;
    logic [SHIFT_SIZE-1:0]  sh_v;

    assign opcode     = instr[6:0];
    assign f3         = instr[14:12];
    assign f7         = instr[31:25];
    assign imm_sext   = sext12(instr[31:20]);
    assign upper_zext = {{(XLEN-20){1'b0}}, instr[31:12]};

    always_comb begin
        op_v    = ALU_ADD;
        legal_v = 1'b1;
        a_v     = '0;
        b_v     = '0;
        sh_v    = '0;
        case (opcode)
            OPC_OP_IMM: begin
                a_v  = rs1;
                b_v  = imm_sext;
                sh_v = instr[25:20];
                case (f3)
                    3'b000: op_v = ALU_ADD;
                    3'b010: op_v = ALU_SLT;
                    3'b011: op_v = ALU_SLTU;
                    3'b100: op_v = ALU_XOR;
                    3'b110: op_v = ALU_OR;
                    3'b111: op_v = ALU_AND;
                    3'b001: begin
                        op_v    = ALU_SLL;
                        legal_v = (instr[31:26] == F7_BASE[6:1]);
                    end
                    default: begin
                        // RV64 shifts use imm[5] as shamt bit, so only imm[11:6] picks SRL/SRA
                        if (instr[31:26] == F7_BASE[6:1])
                            op_v = ALU_SRL;
                        else if (instr[31:26] == F7_ALT[6:1])
                            op_v = ALU_SRA;
                        else
                            legal_v = 1'b0;
                    end
                endcase
            end
            OPC_OP: begin
                a_v  = rs1;
                b_v  = rs2;
                sh_v = rs2[5:0];
                case (f3)
                    3'b000:  op_v = ALU_ADD;
                    3'b001:  op_v = ALU_SLL;
                    3'b010:  op_v = ALU_SLT;
                    3'b011:  op_v = ALU_SLTU;
                    3'b100:  op_v = ALU_XOR;
                    3'b101:  op_v = ALU_SRL;
                    3'b110:  op_v = ALU_OR;
                    default: op_v = ALU_AND;
                endcase
                if (f7 == F7_ALT) begin
                    if (f3 == 3'b000)
                        op_v = ALU_SUB;
                    else if (f3 == 3'b101)
                        op_v = ALU_SRA;
                    else
                        legal_v = 1'b0;
                end else if (f7 != F7_BASE) begin
                    legal_v = 1'b0;
                end
            end
            OPC_OP_IMM32: begin
                a_v  = rs1;
                b_v  = imm_sext;
                sh_v = {1'b0, instr[24:20]};
                case (f3)
                    3'b000: op_v = ALU_ADDW;
                    3'b001: begin
                        op_v    = ALU_SLLW;
                        legal_v = (f7 == F7_BASE);
                    end
                    3'b101: begin
                        if (f7 == F7_BASE)
                            op_v = ALU_SRLW;
                        else if (f7 == F7_ALT)
                            op_v = ALU_SRAW;
                        else
                            legal_v = 1'b0;
                    end
                    default: legal_v = 1'b0;
                endcase
            end
            OPC_OP32: begin
                a_v  = rs1;
                b_v  = rs2;
                sh_v = {1'b0, rs2[4:0]};
                case (f3)
                    3'b000: begin
                        if (f7 == F7_BASE)
                            op_v = ALU_ADDW;
                        else if (f7 == F7_ALT)
                            op_v = ALU_SUBW;
                        else
                            legal_v = 1'b0;
                    end
                    3'b001: begin
                        op_v    = ALU_SLLW;
                        legal_v = (f7 == F7_BASE);
                    end
                    3'b101: begin
                        if (f7 == F7_BASE)
                            op_v = ALU_SRLW;
                        else if (f7 == F7_ALT)
                            op_v = ALU_SRAW;
                        else
                            legal_v = 1'b0;
                    end
                    default: legal_v = 1'b0;
                endcase
            end
            OPC_LUI: begin
                op_v = ALU_LUI;
                a_v  = upper_zext;
            end
            OPC_AUIPC: begin
                op_v = ALU_AUIPC;
                a_v  = upper_zext;
                b_v  = pc;
            end
            default: legal_v = 1'b0;
        endcase

        issue = '0;
        if (legal_v) begin
            issue.sel       = op_v;
            issue.shift_amt = sh_v;
            issue.a         = a_v;
            issue.b         = b_v;
            issue.rd        = instr[11:7];
        end else begin
            issue.illegal   = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// RV64I ALU issue stage: decode plus a registered valid/ready output.
// Define ALU_ISSUE_SKID_EN for a 1-entry skid buffer with a flopped in_ready.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [XLEN-1:0]     in_pc,
    input  logic [XLEN-1:0]     in_rs1_data,
    input  logic [XLEN-1:0]     in_rs2_data,
    alu_issue_stage_if.master   alu_bus
);

    alu_issue_t dec_issue;
    alu_issue_t out_reg;
    logic       out_valid_reg;
    logic       out_free;
    logic       accept;

    alu_op_decoder u_decoder (
        .instr (in_instr),
        .pc    (in_pc),
        .rs1   (in_rs1_data),
        .rs2   (in_rs2_data),
        .issue (dec_issue)
    );

    assign out_free = ~out_valid_reg | alu_bus.out_ready;

`ifdef ALU_ISSUE_SKID_EN
    alu_issue_t skid_reg;
    logic       skid_full_reg;

    // in_ready depends only on a flop, so out_ready never reaches upstream combinationally
    assign in_ready = ~skid_full_reg;
    assign accept   = in_valid & in_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
            skid_full_reg <= 1'b0;
            skid_reg      <= '0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
            skid_full_reg <= 1'b0;
        end else if (out_free) begin
            if (skid_full_reg) begin
                out_reg       <= skid_reg;
                out_valid_reg <= 1'b1;
                skid_full_reg <= 1'b0;
            end else if (accept) begin
                out_reg       <= dec_issue;
                out_valid_reg <= 1'b1;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end else if (accept) begin
            skid_reg      <= dec_issue;
            skid_full_reg <= 1'b1;
        end
    end
`else
    assign in_ready = out_free;
    assign accept   = in_valid & in_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (out_free) begin
            out_valid_reg <= accept;
            if (accept)
                out_reg <= dec_issue;
        end
    end
`endif

    assign alu_bus.out_valid     = out_valid_reg;
    assign alu_bus.alu_enable    = out_valid_reg & ~out_reg.illegal;
    assign alu_bus.alu_sel       = out_reg.sel;
    assign alu_bus.alu_shift_amt = out_reg.shift_amt;
    assign alu_bus.alu_data_in_a = out_reg.a;
    assign alu_bus.alu_data_in_b = out_reg.b;
    assign alu_bus.out_rd        = out_reg.rd;
    assign alu_bus.out_illegal   = out_reg.illegal;

endmodule
